// File: rtl/tq_tr_sched.sv
// Row-issue scheduler sharing one 1-D transform core between a forward and an
// inverse TU requester, with round-robin arbitration on simultaneous requests.
module tq_tr_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       fwd_req_i,
  input  logic [1:0] fwd_size_i,
  output logic       fwd_ack_o,
  input  logic       inv_req_i,
  input  logic [1:0] inv_size_i,
  output logic       inv_ack_o,
  input  logic       stall_i,
  output logic       tr_inverse_o,
  output logic       tr_valid_o,
  output logic [4:0] tr_row_o,
  output logic       tr_last_o,
  output logic       done_fwd_o,
  output logic       done_inv_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StRunFwd, StRunInv} state_e;

  state_e     state_q;
  logic [1:0] size_q;
  logic [4:0] row_q;
  logic       prefer_inv_q;
  logic       fwd_ack_q, inv_ack_q, done_fwd_q, done_inv_q, busy_q;

  logic       running;
  logic [5:0] num_rows;
  logic       last_row;
  logic       grant_fwd, grant_inv;

  always_comb begin
    running      = (state_q != StIdle);
    num_rows     = 6'd4 << size_q;
    last_row     = (row_q == 5'(num_rows - 6'd1));
    tr_valid_o   = running && !stall_i;
    tr_last_o    = tr_valid_o && last_row;
    tr_inverse_o = (state_q == StRunInv);
    tr_row_o     = row_q;
    // On a tie the requester that lost the previous grant wins.
    grant_fwd    = fwd_req_i && (!inv_req_i || !prefer_inv_q);
    grant_inv    = inv_req_i && !grant_fwd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      size_q       <= 2'd0;
      row_q        <= 5'd0;
      prefer_inv_q <= 1'b0;
      fwd_ack_q    <= 1'b0;
      inv_ack_q    <= 1'b0;
      done_fwd_q   <= 1'b0;
      done_inv_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fwd_ack_q  <= 1'b0;
      inv_ack_q  <= 1'b0;
      done_fwd_q <= 1'b0;
      done_inv_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_fwd || grant_inv) begin
            state_q      <= grant_fwd ? StRunFwd : StRunInv;
            size_q       <= grant_fwd ? fwd_size_i : inv_size_i;
            row_q        <= 5'd0;
            fwd_ack_q    <= grant_fwd;
            inv_ack_q    <= grant_inv;
            prefer_inv_q <= grant_fwd;
            busy_q       <= 1'b1;
          end
        end
        StRunFwd, StRunInv: begin
          if (tr_valid_o) begin
            if (last_row) begin
              state_q    <= StIdle;
              row_q      <= 5'd0;
              busy_q     <= 1'b0;
              done_fwd_q <= (state_q == StRunFwd);
              done_inv_q <= (state_q == StRunInv);
            end else begin
              row_q <= row_q + 5'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fwd_ack_o  = fwd_ack_q;
  assign inv_ack_o  = inv_ack_q;
  assign done_fwd_o = done_fwd_q;
  assign done_inv_o = done_inv_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_tq_tr_sched.sv
// Bench for tq_tr_sched: directed literal scenarios plus random traffic, all
// checked every cycle against a TU-level reference model.
module tb_tq_tr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fwd_req_i = 1'b0;
  logic [1:0] fwd_size_i = 2'd0;
  logic       inv_req_i = 1'b0;
  logic [1:0] inv_size_i = 2'd0;
  logic       stall_i = 1'b0;
  logic       fwd_ack_o, inv_ack_o, tr_inverse_o, tr_valid_o, tr_last_o;
  logic       done_fwd_o, done_inv_o, busy_o;
  logic [4:0] tr_row_o;

  int checks = 0;
  int failures = 0;

  tq_tr_sched dut (
    .clk         (clk),
    .rst         (rst),
    .fwd_req_i   (fwd_req_i),
    .fwd_size_i  (fwd_size_i),
    .fwd_ack_o   (fwd_ack_o),
    .inv_req_i   (inv_req_i),
    .inv_size_i  (inv_size_i),
    .inv_ack_o   (inv_ack_o),
    .stall_i     (stall_i),
    .tr_inverse_o(tr_inverse_o),
    .tr_valid_o  (tr_valid_o),
    .tr_row_o    (tr_row_o),
    .tr_last_o   (tr_last_o),
    .done_fwd_o  (done_fwd_o),
    .done_inv_o  (done_inv_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which TU is active (0 none, 1 fwd, 2 inv), its length and
  // how many rows it has issued; pulses are expected one cycle after their cause.
  bit m_known = 0;
  int m_mode = 0;
  int m_row = 0;
  int m_rows = 4;
  bit m_pref_inv = 0;
  bit m_ackf = 0, m_acki = 0, m_donef = 0, m_donei = 0;
  bit ev, el;
  int win;

  always @(negedge clk) begin
    ev = (m_mode != 0) && !stall_i;
    el = ev && (m_row == m_rows - 1);
    if (m_known) begin
      chk("model tr_valid", tr_valid_o, ev);
      chk("model tr_last", tr_last_o, el);
      chk("model tr_row", tr_row_o, m_row);
      chk("model tr_inverse", tr_inverse_o, m_mode == 2);
      chk("model busy", busy_o, m_mode != 0);
      chk("model fwd_ack", fwd_ack_o, m_ackf);
      chk("model inv_ack", inv_ack_o, m_acki);
      chk("model done_fwd", done_fwd_o, m_donef);
      chk("model done_inv", done_inv_o, m_donei);
    end
    m_ackf = 0; m_acki = 0; m_donef = 0; m_donei = 0;
    if (rst) begin
      m_known = 1; m_mode = 0; m_row = 0; m_pref_inv = 0;
    end else if (m_mode == 0) begin
      win = 0;
      if (fwd_req_i && inv_req_i) win = m_pref_inv ? 2 : 1;
      else if (fwd_req_i) win = 1;
      else if (inv_req_i) win = 2;
      if (win != 0) begin
        m_mode = win;
        m_rows = 4 << int'(win == 1 ? fwd_size_i : inv_size_i);
        m_row = 0;
        m_ackf = (win == 1);
        m_acki = (win == 2);
        m_pref_inv = (win == 1);
      end
    end else if (ev) begin
      if (el) begin
        m_donef = (m_mode == 1);
        m_donei = (m_mode == 2);
        m_mode = 0;
        m_row = 0;
      end else begin
        m_row++;
      end
    end
  end

  // The reset edge is the first posedge of the following scenario loop.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; fwd_req_i = 1'b0; inv_req_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid, nrow, nlast, last_k, done_k;
    bit st31;
    repeat (3) @(posedge clk);

    // Forward 4x4, no stall.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; fwd_req_i = (k == 0); fwd_size_i = 2'd0;
      @(negedge clk);
      chk("A fwd_ack", fwd_ack_o, k == 1);
      chk("A valid", tr_valid_o, k >= 1 && k <= 4);
      if (k >= 1 && k <= 4) chk("A row", tr_row_o, k - 1);
      chk("A last", tr_last_o, k == 4);
      chk("A done_fwd", done_fwd_o, k == 5);
      chk("A inverse", tr_inverse_o, 0);
      chk("A busy", busy_o, k >= 1 && k <= 4);
    end

    // Tie after reset, both 8x8: forward first, then inverse.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; fwd_req_i = (k == 0); inv_req_i = (k <= 9);
      fwd_size_i = 2'd1; inv_size_i = 2'd1;
      @(negedge clk);
      chk("B fwd_ack", fwd_ack_o, k == 1);
      chk("B inv_ack", inv_ack_o, k == 10);
      chk("B valid", tr_valid_o, (k >= 1 && k <= 8) || (k >= 10 && k <= 17));
      chk("B inverse", tr_inverse_o, k >= 10 && k <= 17);
      if (k >= 1 && k <= 8) chk("B fwd row", tr_row_o, k - 1);
      if (k >= 10 && k <= 17) chk("B inv row", tr_row_o, k - 10);
      chk("B last", tr_last_o, k == 8 || k == 17);
      chk("B done_fwd", done_fwd_o, k == 9);
      chk("B done_inv", done_inv_o, k == 18);
    end

    // Inverse 32x32 with stalls on 5..7 and on the first row-31 cycle.
    do_reset();
    nvalid = 0; nrow = 0; nlast = 0; last_k = -1; done_k = -1; st31 = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; inv_req_i = (k == 0); inv_size_i = 2'd3;
      stall_i = (k >= 5 && k <= 7);
      if (busy_o && tr_row_o == 5'd31 && !st31) begin
        stall_i = 1'b1;
        st31 = 1;
      end
      @(negedge clk);
      if (tr_valid_o) begin
        chk("C row order", tr_row_o, nrow);
        chk("C inverse", tr_inverse_o, 1);
        nrow++;
        nvalid++;
      end
      if (tr_last_o) begin nlast++; last_k = k; end
      if (done_inv_o && done_k < 0) done_k = k;
    end
    stall_i = 1'b0;
    chk("C strobes", nvalid, 32);
    chk("C last count", nlast, 1);
    chk("C last cycle", last_k, 36);
    chk("C done cycle", done_k, 37);

    // Reset during row 10 of a forward 16x16, then a tie.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      rst = (k == 11); fwd_req_i = (k == 0 || k == 13); inv_req_i = (k == 13);
      fwd_size_i = 2'd2; inv_size_i = 2'd0;
      @(negedge clk);
      if (k == 11) chk("D row at reset", tr_row_o, 10);
      if (k == 12) begin
        chk("D busy after reset", busy_o, 0);
        chk("D valid after reset", tr_valid_o, 0);
      end
      chk("D done_fwd", done_fwd_o, 0);
      chk("D fwd_ack", fwd_ack_o, k == 1 || k == 14);
      chk("D inv_ack", inv_ack_o, 0);
    end

    // Size change during a forward 4x4 run.
    do_reset();
    nvalid = 0; done_k = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; fwd_req_i = (k == 0); fwd_size_i = (k == 0) ? 2'd0 : 2'd3;
      @(negedge clk);
      if (tr_valid_o) nvalid++;
      if (done_fwd_o && done_k < 0) done_k = k;
    end
    chk("E rows", nvalid, 4);
    chk("E done cycle", done_k, 5);

    // Random traffic; requesters hold until acked, sizes wander freely.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      if (fwd_ack_o) fwd_req_i = 1'b0;
      else if (!fwd_req_i && $urandom_range(0, 3) == 0) fwd_req_i = 1'b1;
      if (inv_ack_o) inv_req_i = 1'b0;
      else if (!inv_req_i && $urandom_range(0, 3) == 0) inv_req_i = 1'b1;
      fwd_size_i = 2'($urandom);
      inv_size_i = 2'($urandom);
      stall_i = ($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tq_tr_sched.md
TQ_TR_SCHED -- requirements
Module: tq_tr_sched

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst  in  1  synchronous, active-high reset
  fwd_req_i  in  1  forward-transform TU request; held until fwd_ack_o
  fwd_size_i  in  2  forward TU size: 0=4x4, 1=8x8, 2=16x16, 3=32x32
  fwd_ack_o  out  1  one-cycle pulse: forward TU accepted
  inv_req_i  in  1  inverse-transform TU request; held until inv_ack_o
  inv_size_i  in  2  inverse TU size, same encoding
  inv_ack_o  out  1  one-cycle pulse: inverse TU accepted
  stall_i  in  1  downstream backpressure; no row issued while high
  tr_inverse_o  out  1  direction to shared 1-D transform core (1=inverse)
  tr_valid_o  out  1  row-issue strobe to shared core
  tr_row_o  out  5  row index of current issue, 0..31
  tr_last_o  out  1  high with tr_valid_o on final row of TU
  done_fwd_o  out  1  one-cycle pulse: forward TU fully issued
  done_inv_o  out  1  one-cycle pulse: inverse TU fully issued
  busy_o  out  1  high whenever state is not IDLE
REQ-002 Clock port SHALL be clk; reset SHALL be rst, synchronous, active-high; the block SHALL have exactly one clock.

Function
REQ-003 The FSM SHALL have states IDLE, RUN_FWD, RUN_INV.
REQ-004 Requests SHALL be sampled only in IDLE; requests during RUN_* SHALL be ignored until return to IDLE.
REQ-005 In IDLE with exactly one request high, that requester SHALL be granted.
REQ-006 In IDLE with both requests high, grant SHALL go to the requester not granted most recently (round-robin); after reset, forward SHALL win the first tie.
REQ-007 On grant in cycle n: state SHALL be RUN_FWD/RUN_INV in cycle n+1; the matching ack SHALL be high in cycle n+1 only; size SHALL be latched; row counter SHALL be 0.
REQ-008 Row count N SHALL be 4 << size (4, 8, 16, 32).
REQ-009 tr_valid_o SHALL equal (state is RUN_*) AND NOT stall_i (combinational from registered state).
REQ-010 tr_inverse_o SHALL be 1 in RUN_INV, 0 in RUN_FWD, and 0 in IDLE.
REQ-011 tr_row_o SHALL equal the row counter; the counter SHALL increment by 1 on each cycle tr_valid_o is high and hold otherwise.
REQ-012 tr_last_o SHALL be high iff tr_valid_o is high and row counter == N-1.
REQ-013 On a cycle with tr_last_o high: the next state SHALL be IDLE; the row counter SHALL clear; the matching done pulse SHALL be high for exactly the following cycle.
REQ-014 The block SHALL spend a minimum of one IDLE cycle between TUs; the earliest new grant SHALL be sampled in the cycle done is high.
REQ-015 Stall on the last row SHALL hold the row counter at N-1 with no tr_last_o; the TU SHALL complete on the first unstalled cycle.
REQ-016 Size inputs SHALL be ignored except in the grant cycle; changes during RUN_* SHALL have no effect.
REQ-017 busy_o SHALL be high in RUN_FWD and RUN_INV, and low in IDLE.

Reset
REQ-018 With rst high at a clock edge, the block SHALL enter IDLE, clear the row counter, and set the round-robin pointer to favour forward.
REQ-019 With rst high at a clock edge, all registered outputs (acks, dones, busy_o) SHALL be 0; tr_valid_o, tr_last_o and tr_inverse_o SHALL follow to 0 through IDLE.
REQ-020 Reset mid-TU SHALL abort the TU with no done pulse; the aborted requester SHALL re-request.

Verification
REQ-021 Fwd 4x4 req at cycle 0, no stall -> fwd_ack_o at 1; tr_valid_o at 1..4 with rows 0..3; tr_last_o at 4; done_fwd_o at 5; tr_inverse_o=0 throughout.
REQ-022 Both req held from cycle 0, sizes 8x8 -> fwd granted first (ack 1, rows 1..8, done 9); inv_ack_o at 10; inverse rows 10..17 with tr_inverse_o=1; done_inv_o at 18.
REQ-023 Inv 32x32, stall_i high on cycles 5..7 and on the row-31 cycle -> exactly 32 valid strobes, no row skipped or repeated, tr_last_o only on the unstalled row-31 cycle.
REQ-024 rst pulsed during row 10 of a fwd 16x16 -> next cycle IDLE, busy_o=0, no done_fwd_o; a subsequent tie grants forward.
REQ-025 fwd_size_i changed from 0 to 3 during RUN_FWD of a 4x4 -> still exactly 4 rows issued.
